// File: rtl/seq_detect_ctrl_if.sv
// Control/stream bundle for seq_detect_ctrl: run configuration and the serial bit
// source in one direction, progress and status in the other.
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 16
);
    logic             start_i;
    logic             abort_i;
    logic [PAT_W-1:0] cfg_pat_i;
    logic             cfg_overlap_i;
    logic [CNT_W-1:0] cfg_target_i;
    logic [TO_W-1:0]  cfg_timeout_i;
    logic             bit_valid_i;
    logic             bit_i;
    logic             busy_o;
    logic             match_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic             done_o;
    logic             timeout_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, abort_i, cfg_pat_i, cfg_overlap_i, cfg_target_i, cfg_timeout_i,
        output bit_valid_i, bit_i,
        input  busy_o, match_o, match_cnt_o, done_o, timeout_o, state_o
    );

    modport slave (
        input  start_i, abort_i, cfg_pat_i, cfg_overlap_i, cfg_target_i, cfg_timeout_i,
        input  bit_valid_i, bit_i,
        output busy_o, match_o, match_cnt_o, done_o, timeout_o, state_o
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for a serial pattern detector: arms on start, counts pattern
// matches on a qualified bit stream, and ends on target, timeout or abort.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    seq_detect_ctrl_if.slave   bus
);
    localparam int FILL_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              match_q;
    logic              done_q;
    logic              timeout_pulse_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [PAT_W-1:0]  pat_q;
    logic              overlap_q;
    logic [CNT_W-1:0]  target_q;
    logic [TO_W-1:0]   timeout_q;

    // Only the last PAT_W-1 bits are kept; the incoming bit completes the window.
    logic [PAT_W-2:0]  shift_q;
    logic [FILL_W-1:0] fill_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic [PAT_W-1:0]  cand;
    logic              hit;
    logic              to_expired;
    logic [CNT_W-1:0]  cnt_inc;
    logic [FILL_W-1:0] fill_inc;

    assign cand       = {shift_q, bus.bit_i};
    assign hit        = bus.bit_valid_i && (fill_q >= FILL_W'(PAT_W - 1)) && (cand == pat_q);
    assign to_expired = (timeout_q != '0) && (to_cnt_q == timeout_q);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign fill_inc   = (fill_q == FILL_W'(PAT_W - 1)) ? fill_q : fill_q + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            match_q         <= 1'b0;
            done_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
            cnt_q           <= '0;
            pat_q           <= '0;
            overlap_q       <= 1'b0;
            target_q        <= '0;
            timeout_q       <= '0;
            shift_q         <= '0;
            fill_q          <= '0;
            to_cnt_q        <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees pre-edge values;
            // the pulse outputs default low and only the raising branch overrides them.
            match_q         <= 1'b0;
            done_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        state_q <= S_ARM;
                        busy_q  <= 1'b1;
                    end
                end

                S_ARM: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        pat_q     <= bus.cfg_pat_i;
                        overlap_q <= bus.cfg_overlap_i;
                        target_q  <= bus.cfg_target_i;
                        timeout_q <= bus.cfg_timeout_i;
                        shift_q   <= '0;
                        fill_q    <= '0;
                        cnt_q     <= '0;
                        to_cnt_q  <= '0;
                        state_q   <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        match_q  <= 1'b1;
                        cnt_q    <= cnt_inc;
                        to_cnt_q <= '0;
                        if (overlap_q) begin
                            shift_q <= cand[PAT_W-2:0];
                            fill_q  <= fill_inc;
                        end else begin
                            shift_q <= '0;
                            fill_q  <= '0;
                        end
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        if (bus.bit_valid_i) begin
                            shift_q <= cand[PAT_W-2:0];
                            fill_q  <= fill_inc;
                        end
                        // Expiry is seen one cycle after the counter reaches the limit.
                        if (to_expired) begin
                            timeout_pulse_q <= 1'b1;
                            state_q         <= S_IDLE;
                            busy_q          <= 1'b0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.match_o     = match_q;
    assign bus.match_cnt_o = cnt_q;
    assign bus.done_o      = done_q;
    assign bus.timeout_o   = timeout_pulse_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a queue-based model checked against the DUT every
// cycle, plus hand-computed expectations at the notable points of each scenario.
module tb_seq_detect_ctrl;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int TO_W    = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..3, accepted-bit history, quiet-cycle count.
    int       m_state;
    bit       m_match, m_done, m_to;
    int       m_cnt;
    int       quiet;
    bit       hist[$];
    logic [PAT_W-1:0] l_pat;
    bit       l_ovl;
    int       l_tgt, l_tmo;

    function automatic bit tail_is_pattern();
        if (hist.size() < PAT_W) return 1'b0;
        for (int i = 0; i < PAT_W; i++)
            if (hist[hist.size() - PAT_W + i] != l_pat[PAT_W-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_match = 0; m_done = 0; m_to = 0; m_cnt = 0; quiet = 0;
            hist.delete();
        end else begin
            m_match = 0; m_done = 0; m_to = 0;
            case (m_state)
                0: if (bus.start_i && !bus.abort_i) m_state = 1;
                1: if (bus.abort_i) m_state = 0;
                   else begin
                       l_pat = bus.cfg_pat_i; l_ovl = bus.cfg_overlap_i;
                       l_tgt = int'(bus.cfg_target_i); l_tmo = int'(bus.cfg_timeout_i);
                       hist.delete(); quiet = 0; m_cnt = 0; m_state = 2;
                   end
                2: if (bus.abort_i) m_state = 0;
                   else begin
                       bit hit;
                       hit = 0;
                       if (bus.bit_valid_i) begin
                           hist.push_back(bus.bit_i);
                           if (hist.size() > PAT_W) void'(hist.pop_front());
                           hit = tail_is_pattern();
                       end
                       if (hit) begin
                           m_match = 1; quiet = 0;
                           if (m_cnt < CNT_MAX) m_cnt++;
                           if (!l_ovl) hist.delete();
                           if (l_tgt != 0 && m_cnt == l_tgt) begin m_done = 1; m_state = 3; end
                       end else if (l_tmo != 0 && quiet == l_tmo) begin
                           m_to = 1; m_state = 0;
                       end else quiet++;
                   end
                default: m_state = 0;
            endcase
        end
    end

    int n_match, n_done, n_to;

    always @(negedge clk) begin
        check("busy",    bus.busy_o,      (m_state != 0) ? 1 : 0);
        check("state",   bus.state_o,     m_state);
        check("match",   bus.match_o,     m_match);
        check("cnt",     bus.match_cnt_o, m_cnt);
        check("done",    bus.done_o,      m_done);
        check("timeout", bus.timeout_o,   m_to);
        if (bus.match_o)   n_match++;
        if (bus.done_o)    n_done++;
        if (bus.timeout_o) n_to++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [PAT_W-1:0] pat, input bit ovl, input int tgt, input int tmo);
        tick();
        bus.cfg_pat_i     = pat;
        bus.cfg_overlap_i = ovl;
        bus.cfg_target_i  = CNT_W'(tgt);
        bus.cfg_timeout_i = TO_W'(tmo);
        bus.start_i       = 1'b1;
        n_match = 0; n_done = 0; n_to = 0;
        tick();
        bus.start_i = 1'b0;
        check("arm_state", bus.state_o, 1);
        tick();
        check("run_state", bus.state_o, 2);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.bit_valid_i = 1'b1;
            bus.bit_i       = bits[i];
            tick();
        end
        bus.bit_valid_i = 1'b0;
    endtask

    task automatic send_const(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.bit_valid_i = 1'b1;
            bus.bit_i       = b;
            tick();
        end
        bus.bit_valid_i = 1'b0;
    endtask

    task automatic abort_run();
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start_i = 0; bus.abort_i = 0; bus.cfg_pat_i = '0; bus.cfg_overlap_i = 0;
        bus.cfg_target_i = '0; bus.cfg_timeout_i = '0; bus.bit_valid_i = 0; bus.bit_i = 0;
        tick(); tick();
        check("rst_busy",  bus.busy_o, 0);
        check("rst_state", bus.state_o, 0);
        check("rst_cnt",   bus.match_cnt_o, 0);
        rst = 1'b0;

        // Non-overlap, target 2; cfg changes after ARM must not matter.
        start_run(4'b1011, 1'b0, 2, 0);
        bus.cfg_pat_i = 4'b0000; bus.cfg_target_i = 8'd1;
        send_bits(32'b1011, 4);
        check("t1_match1", bus.match_o, 1);
        check("t1_cnt1",   bus.match_cnt_o, 1);
        check("t1_state1", bus.state_o, 2);
        send_bits(32'b1011, 4);
        check("t1_match2", bus.match_o, 1);
        check("t1_done",   bus.done_o, 1);
        check("t1_state3", bus.state_o, 3);
        check("t1_cnt2",   bus.match_cnt_o, 2);
        tick();
        check("t1_idle",   bus.state_o, 0);
        check("t1_hold",   bus.match_cnt_o, 2);
        check("t1_nmatch", n_match, 2);
        check("t1_ndone",  n_done, 1);

        // Overlap allowed vs. not, same stream 1010101.
        start_run(4'b1010, 1'b1, 0, 0);
        send_bits(32'b1010101, 7);
        check("t2a_cnt", bus.match_cnt_o, 2);
        abort_run();
        check("t2a_idle", bus.state_o, 0);
        tick();
        check("t2a_hold",   bus.match_cnt_o, 2);
        check("t2a_nmatch", n_match, 2);

        start_run(4'b1010, 1'b0, 0, 0);
        send_bits(32'b1010101, 7);
        abort_run();
        check("t2b_idle",   bus.state_o, 0);
        check("t2b_cnt",    bus.match_cnt_o, 1);
        check("t2b_nmatch", n_match, 1);

        // start and abort together in IDLE: abort wins.
        tick();
        bus.start_i = 1'b1; bus.abort_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        check("sa_state", bus.state_o, 0);
        check("sa_busy",  bus.busy_o, 0);

        // Timeout with no valid bits: pulse 11 cycles after RUN entry.
        start_run(4'b1011, 1'b0, 1, 10);
        repeat (10) tick();
        check("t3_pre_to",    bus.timeout_o, 0);
        check("t3_pre_state", bus.state_o, 2);
        tick();
        check("t3_to",    bus.timeout_o, 1);
        check("t3_state", bus.state_o, 0);
        check("t3_cnt",   bus.match_cnt_o, 0);
        tick();
        check("t3_to_pulse", bus.timeout_o, 0);
        check("t3_nto",      n_to, 1);
        check("t3_ndone",    n_done, 0);

        // Gapped bits with a stray start during RUN.
        start_run(4'b1011, 1'b0, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] p;
            p = 4'b1011;
            send_bits({31'd0, p[i]}, 1);
            if (i == 2) bus.start_i = 1'b1;
            tick();
            bus.start_i = 1'b0;
            tick(); tick();
        end
        check("t4_state",  bus.state_o, 2);
        check("t4_cnt",    bus.match_cnt_o, 1);
        check("t4_nmatch", n_match, 1);
        abort_run();

        // Abort mid-run, with a would-be match on the abort cycle.
        start_run(4'b1011, 1'b0, 3, 0);
        send_bits(32'b1011, 4);
        send_bits(32'b101, 3);
        bus.bit_valid_i = 1'b1; bus.bit_i = 1'b1;
        abort_run();
        bus.bit_valid_i = 1'b0;
        check("t5_state",  bus.state_o, 0);
        check("t5_cnt",    bus.match_cnt_o, 1);
        check("t5_match",  bus.match_o, 0);
        check("t5_nmatch", n_match, 1);
        check("t5_ndone",  n_done, 0);
        check("t5_nto",    n_to, 0);

        // Match and timeout expiry on the same edge: match wins.
        start_run(4'b1011, 1'b0, 0, 3);
        send_bits(32'b1011, 4);
        check("t6_match", bus.match_o, 1);
        check("t6_to",    bus.timeout_o, 0);
        check("t6_state", bus.state_o, 2);
        repeat (3) tick();
        check("t6_still_run", bus.state_o, 2);
        tick();
        check("t6_to_late", bus.timeout_o, 1);

        // Counter saturation with target 0.
        start_run(4'b1111, 1'b1, 0, 0);
        send_const(1'b1, 262);
        check("t7_cnt_sat", bus.match_cnt_o, 255);
        check("t7_match",   bus.match_o, 1);
        abort_run();

        // Asynchronous reset between clock edges, then a normal run.
        start_run(4'b1011, 1'b0, 0, 0);
        send_bits(32'b1011, 4);
        check("t8_cnt_pre", bus.match_cnt_o, 1);
        #2 rst = 1'b1;
        #1;
        check("t8_rst_busy",  bus.busy_o, 0);
        check("t8_rst_state", bus.state_o, 0);
        check("t8_rst_cnt",   bus.match_cnt_o, 0);
        tick();
        rst = 1'b0;
        start_run(4'b1011, 1'b0, 1, 0);
        send_bits(32'b1011, 4);
        check("t8_done",  bus.done_o, 1);
        check("t8_state", bus.state_o, 3);
        check("t8_cnt",   bus.match_cnt_o, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
